// File: rtl/mem_ss_emif_csr_rsp.sv
// EMIF DFH CSR responder: DFH/capability/status reads, memory-subsystem reset sequencing and
// calibration tracking. Optional calibration timer at 0x20 built when MEM_SS_CAL_TIMER_EN is defined.
module mem_ss_emif_csr_rsp #(
  parameter int unsigned NUM_MEM_CH      = 4,
  parameter logic [11:0] FEAT_ID         = 12'h009,
  parameter logic [23:0] NEXT_DFH_OFFSET = 24'h001000,
  parameter logic        END_OF_LIST     = 1'b0,
  parameter int unsigned ACK_TIMEOUT     = 4096,
  parameter int unsigned RST_HOLD        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csr_wr_valid,
  input  logic [7:0]            csr_wr_addr,
  input  logic [63:0]           csr_wr_data,
  input  logic                  csr_rd_valid,
  input  logic [7:0]            csr_rd_addr,
  output logic                  csr_rdata_valid,
  output logic [63:0]           csr_rdata,
  output logic                  mem_ss_rst_req,
  input  logic                  mem_ss_rst_ack_n,
  input  logic [NUM_MEM_CH-1:0] mem_cal_success,
  input  logic [NUM_MEM_CH-1:0] mem_cal_fail
);

  localparam int unsigned MaxCnt = (ACK_TIMEOUT > RST_HOLD) ? ACK_TIMEOUT : RST_HOLD;
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

  typedef enum logic [2:0] {
    StRstHold, StWaitAck, StRelease, StWaitCal, StReady, StError
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic                  rst_req_q;
  logic                  cal_phase_q;
  logic                  ack_n_meta_q, ack_n_sync_q;
  logic [NUM_MEM_CH-1:0] success_meta_q, success_sync_q;
  logic [NUM_MEM_CH-1:0] fail_meta_q, fail_sync_q;
  logic                  restart;
  logic [63:0]           rd_data;
  logic                  unused_wr_data;

  assign unused_wr_data = ^csr_wr_data[63:1];
  assign restart        = csr_wr_valid && (csr_wr_addr == 8'h18) && csr_wr_data[0];
  assign mem_ss_rst_req = rst_req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_n_meta_q   <= 1'b1;
      ack_n_sync_q   <= 1'b1;
      success_meta_q <= '0;
      success_sync_q <= '0;
      fail_meta_q    <= '0;
      fail_sync_q    <= '0;
    end else begin
      ack_n_meta_q   <= mem_ss_rst_ack_n;
      ack_n_sync_q   <= ack_n_meta_q;
      success_meta_q <= mem_cal_success;
      success_sync_q <= success_meta_q;
      fail_meta_q    <= mem_cal_fail;
      fail_sync_q    <= fail_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state_q     <= StRstHold;
      cnt_q       <= '0;
      rst_req_q   <= 1'b1;
      cal_phase_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRstHold: begin
          if (cnt_q == CntW'(RST_HOLD - 1)) begin
            state_q <= StWaitAck;
            cnt_q   <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitAck: begin
          if (!ack_n_sync_q) begin
            state_q   <= StRelease;
            rst_req_q <= 1'b0;
            cnt_q     <= '0;
          end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
            state_q   <= StError;
            rst_req_q <= 1'b0;
            cnt_q     <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRelease: begin
          state_q     <= StWaitCal;
          cal_phase_q <= 1'b1;
        end
        StWaitCal: begin
          // A failing channel outranks completion seen in the same cycle.
          if (|fail_sync_q)        state_q <= StError;
          else if (&success_sync_q) state_q <= StReady;
        end
        StReady, StError: ;
        default: state_q <= StError;
      endcase
    end
  end

`ifdef MEM_SS_CAL_TIMER_EN
  logic [31:0] cal_timer_q;

  always_ff @(posedge clk) begin
    if (rst || restart || (state_q == StRelease)) begin
      cal_timer_q <= '0;
    end else if ((state_q == StWaitCal) && (cal_timer_q != 32'hFFFF_FFFF)) begin
      cal_timer_q <= cal_timer_q + 32'd1;
    end
  end
`endif

  // Calibration bits are meaningful only once the subsystem has left reset in this sequence.
  logic cal_visible;
  assign cal_visible = (state_q == StWaitCal) || (state_q == StReady) ||
                       ((state_q == StError) && cal_phase_q);

  always_comb begin
    rd_data = '0;
    if (csr_rd_addr[2:0] == 3'b000) begin
      case (csr_rd_addr[7:3])
        5'd0: begin
          rd_data[63:60] = 4'h3;
          rd_data[40]    = END_OF_LIST;
          rd_data[39:16] = NEXT_DFH_OFFSET;
          rd_data[11:0]  = FEAT_ID;
        end
        5'd1: rd_data[NUM_MEM_CH-1:0] = '1;
        5'd2: begin
          if (cal_visible) begin
            rd_data[NUM_MEM_CH-1:0]  = success_sync_q;
            rd_data[16 +: NUM_MEM_CH] = fail_sync_q;
          end
          rd_data[62] = (state_q == StError);
          rd_data[63] = (state_q == StReady);
        end
        5'd3: rd_data[0] = rst_req_q;
`ifdef MEM_SS_CAL_TIMER_EN
        5'd4: rd_data[31:0] = cal_timer_q;
`endif
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csr_rdata_valid <= 1'b0;
      csr_rdata       <= '0;
    end else begin
      csr_rdata_valid <= csr_rd_valid;
      if (csr_rd_valid) csr_rdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_mem_ss_emif_csr_rsp.sv
// Scoreboard bench for mem_ss_emif_csr_rsp: stimulus queues expected read data, a monitor
// compares every response on the falling edge.
module tb_mem_ss_emif_csr_rsp;
  localparam int unsigned NCH    = 4;
  localparam int unsigned ACK_TO = 4096;
  localparam int unsigned HOLD   = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           csr_wr_valid;
  logic [7:0]     csr_wr_addr;
  logic [63:0]    csr_wr_data;
  logic           csr_rd_valid;
  logic [7:0]     csr_rd_addr;
  logic           csr_rdata_valid;
  logic [63:0]    csr_rdata;
  logic           mem_ss_rst_req;
  logic           mem_ss_rst_ack_n;
  logic [NCH-1:0] mem_cal_success;
  logic [NCH-1:0] mem_cal_fail;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];
  logic        exp_valid = 1'b0;
  logic [63:0] last_rdata = '0;

  mem_ss_emif_csr_rsp #(
    .NUM_MEM_CH(NCH), .ACK_TIMEOUT(ACK_TO), .RST_HOLD(HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .csr_wr_valid(csr_wr_valid), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .csr_rd_valid(csr_rd_valid), .csr_rd_addr(csr_rd_addr),
    .csr_rdata_valid(csr_rdata_valid), .csr_rdata(csr_rdata),
    .mem_ss_rst_req(mem_ss_rst_req), .mem_ss_rst_ack_n(mem_ss_rst_ack_n),
    .mem_cal_success(mem_cal_success), .mem_cal_fail(mem_cal_fail)
  );

  always #5 clk = ~clk;

  // Reference for the one-cycle read latency.
  always @(posedge clk) exp_valid <= rst ? 1'b0 : csr_rd_valid;

  always @(negedge clk) begin
    if (!rst) begin
      logic [63:0] e;
      string       n;
      e = '0;
      n = "none";
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: response expected but no entry queued");
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
        end
      end
      if (csr_rdata_valid || exp_valid) begin
        checks++;
        if (csr_rdata_valid !== exp_valid) begin
          errors++;
          $display("FAIL rd_latency(%s): rdata_valid=%0b required=%0b", n, csr_rdata_valid,
                   exp_valid);
        end else begin
          checks++;
          if (csr_rdata !== e) begin
            errors++;
            $display("FAIL %s: got %h required %h", n, csr_rdata, e);
          end
        end
      end else begin
        checks++;
        if (csr_rdata !== last_rdata) begin
          errors++;
          $display("FAIL rdata_hold: got %h required %h", csr_rdata, last_rdata);
        end
      end
      last_rdata = csr_rdata;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, act, req);
    end
  endtask

  task automatic exp_rd(input logic [7:0] a, input logic [63:0] e, input string n);
    csr_rd_valid = 1'b1;
    csr_rd_addr  = a;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d);
    csr_wr_valid = 1'b1;
    csr_wr_addr  = a;
    csr_wr_data  = d;
    @(negedge clk);
    csr_wr_valid = 1'b0;
  endtask

  task automatic wait_drop(input int bound, output int high, output logic dropped);
    high    = 0;
    dropped = 1'b0;
    for (int c = 0; c < bound && !dropped; c++) begin
      @(negedge clk);
      if (mem_ss_rst_req) high++;
      else dropped = 1'b1;
    end
  endtask

  initial begin
    int   high;
    logic dropped;
    rst = 1'b1;
    csr_wr_valid = 1'b0; csr_wr_addr = '0; csr_wr_data = '0;
    csr_rd_valid = 1'b0; csr_rd_addr = '0;
    mem_ss_rst_ack_n = 1'b1; mem_cal_success = '0; mem_cal_fail = '0;
    repeat (4) @(negedge clk);
    chk("reset_rst_req", 64'(mem_ss_rst_req), 64'd1);
    chk("reset_rdata_valid", 64'(csr_rdata_valid), 64'd0);
    chk("reset_rdata", csr_rdata, 64'd0);
    rst = 1'b0;

    // Reset handshake: ack asserted at cycle 20.
    high = 0;
    dropped = 1'b0;
    for (int cyc = 1; cyc <= 200 && !dropped; cyc++) begin
      @(negedge clk);
      if (cyc == 2) begin
        csr_rd_valid = 1'b1; csr_rd_addr = 8'h10;
        exp_q.push_back(64'd0); name_q.push_back("status_in_hold");
      end else if (cyc == 3) begin
        csr_rd_addr = 8'h18;
        exp_q.push_back(64'd1); name_q.push_back("control_in_hold");
      end else begin
        csr_rd_valid = 1'b0;
      end
      if (cyc == 20) mem_ss_rst_ack_n = 1'b0;
      if (mem_ss_rst_req) high++;
      else dropped = 1'b1;
    end
    chk("rst_req_dropped", 64'(dropped), 64'd1);
    chk("rst_req_min_hold", 64'(high >= HOLD), 64'd1);
    chk("rst_req_drop_after_ack", 64'(high >= 20 && high <= 25), 64'd1);

`ifdef MEM_SS_CAL_TIMER_EN
    repeat (98) @(negedge clk);
`endif
    mem_cal_success = 4'hF;
    repeat (6) @(negedge clk);
    chk("rst_req_low_ready", 64'(mem_ss_rst_req), 64'd0);
    exp_rd(8'h10, 64'h8000_0000_0000_000F, "status_ready");
    exp_rd(8'h08, 64'h0000_0000_0000_000F, "capability");
    exp_rd(8'h00, 64'h3000_0000_1000_0009, "dfh");
    exp_rd(8'h28, 64'd0, "unmapped_28");
    exp_rd(8'h04, 64'd0, "misaligned_04");
`ifdef MEM_SS_CAL_TIMER_EN
    exp_rd(8'h20, 64'd100, "cal_timer");
`else
    exp_rd(8'h20, 64'd0, "timer_absent");
`endif
    csr_rd_valid = 1'b0;
    @(negedge clk);

    // Restart from READY with a same-cycle read of CONTROL; ack withheld for timeout.
    mem_ss_rst_ack_n = 1'b1;
    mem_cal_success  = '0;
    csr_wr_valid = 1'b1; csr_wr_addr = 8'h18; csr_wr_data = 64'd1;
    exp_rd(8'h18, 64'd0, "control_pre_write");
    csr_wr_valid = 1'b0;
    chk("restart_rst_req", 64'(mem_ss_rst_req), 64'd1);
    exp_rd(8'h10, 64'd0, "status_after_restart");
    csr_rd_valid = 1'b0;
    wait_drop(6000, high, dropped);
    chk("timeout_dropped", 64'(dropped), 64'd1);
    chk("timeout_length", 64'(high >= ACK_TO + HOLD - 4 && high <= ACK_TO + HOLD), 64'd1);
    exp_rd(8'h10, 64'h4000_0000_0000_0000, "status_timeout");
    exp_rd(8'h18, 64'd0, "control_timeout");
    csr_rd_valid = 1'b0;

    // Calibration failure on channel 2.
    mem_ss_rst_ack_n = 1'b0;
    wr(8'h18, 64'd1);
    wait_drop(100, high, dropped);
    chk("calfail_seq_dropped", 64'(dropped), 64'd1);
    repeat (2) @(negedge clk);
    mem_cal_success = 4'hB;
    mem_cal_fail    = 4'h4;
    repeat (5) @(negedge clk);
    chk("calfail_rst_req", 64'(mem_ss_rst_req), 64'd0);
    exp_rd(8'h10, 64'h4000_0000_0004_000B, "status_cal_fail");
    csr_rd_valid = 1'b0;

    // Fail and full success seen together: fail wins.
    mem_cal_success = 4'hF;
    mem_cal_fail    = 4'h1;
    wr(8'h18, 64'd1);
    exp_rd(8'h10, 64'd0, "status_masked_in_hold");
    csr_rd_valid = 1'b0;
    wait_drop(100, high, dropped);
    chk("failwins_dropped", 64'(dropped), 64'd1);
    repeat (5) @(negedge clk);
    exp_rd(8'h10, 64'h4000_0000_0001_000F, "status_fail_wins");
    csr_rd_valid = 1'b0;

    // Writes that must not restart or alter state.
    wr(8'h18, 64'd0);
    wr(8'h10, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(8'h1C, 64'd1);
    exp_rd(8'h18, 64'd0, "control_after_ignored_writes");
    exp_rd(8'h10, 64'h4000_0000_0001_000F, "status_after_ignored_writes");
    csr_rd_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
